if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch (IF) stage plus the IF/ID pipeline register; directly upstream of the decode/control stage.
//  Holds the PC/nPC pair with one-delay-slot branch semantics and drives the byte-addressed instruction memory.
//  Latches the fetched word and its PC into IF/ID for the control unit.
//  Supports pipeline stall (load-enable low) and IF/ID flush (bubble insertion).
// PARAMETERS
//  ADDR_W    9             instruction memory byte-address width (512-byte memory)
//  RESET_PC  32'h00000000  PC value after reset; nPC resets to RESET_PC+4
//  NOP_WORD  32'h00000000  word loaded into IF/ID on reset or flush
//  CNT_W     16            width of the fetched-instruction counter
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  stall          in   1       1: hold PC, nPC and IF/ID (le_pc = le_npc = ~stall)
//  flush          in   1       1: load NOP_WORD into IF/ID, clear valid
//  branch_taken   in   1       from ID: taken transfer for the instruction now in IF/ID
//  branch_target  in   32      target address; bits [1:0] ignored
//  imem_addr      out  ADDR_W  combinational = pc[ADDR_W-1:0]
//  imem_data      in   32      combinational read word (big-endian) at imem_addr
//  pc             out  32      address of the instruction being fetched
//  npc            out  32      address of the next fetch
//  if_id_instr    out  32      registered instruction for decode
//  if_id_pc       out  32      PC of if_id_instr
//  if_id_valid    out  1       if_id_instr is a real fetched instruction
//  fetch_count    out  CNT_W   number of instructions latched valid, saturating
// BEHAVIOUR
//  Reset (reset==0, immediate, async): pc=RESET_PC, npc=RESET_PC+4, if_id_instr=NOP_WORD,
//   if_id_pc=0, if_id_valid=0, fetch_count=0. Reset mid-operation discards all state; the first fetch after release is RESET_PC.
//  Normal cycle (stall=0, flush=0), every rising edge:
//   if_id_instr<=imem_data; if_id_pc<=pc; if_id_valid<=1; pc<=npc;
//   npc<= branch_taken ? {branch_target[31:2],2'b00} : npc+4.
//  Delayed branch: exactly one delay slot. The slot word is at the pc current when branch_taken
//   is asserted; it is fetched and latched normally. The target is fetched on the following cycle.
//  Stall=1: pc, npc, if_id_* and fetch_count hold; branch_taken ignored (ID holds it until stall drops).
//  Flush=1, stall=0: PC/nPC advance as normal (branch honoured); if_id_instr<=NOP_WORD, if_id_valid<=0.
//  Flush=1, stall=1: flush wins for IF/ID (bubble, valid=0); PC/nPC hold.
//  Arithmetic: pc/npc are 32-bit and wrap modulo 2^32. imem_addr uses the low ADDR_W bits, so the fetch wraps at 2^ADDR_W bytes.
//  pc[1:0] is always 00.
//  fetch_count increments by 1 on each edge that sets if_id_valid=1; it saturates at all-ones.
//  Latency: a word at pc appears on if_id_instr one clock later; a branch_target is fetched 2 clocks after branch_taken.
// TESTING
//  1 Reset: hold reset=0 for 3 clk, then release -> pc=0, npc=4, if_id_valid=0;
//    after the 1st edge, if_id_pc=0 and if_id_instr=mem[0..3].
//  2 Sequential: run 5 edges -> if_id_pc steps 0,4,8,12,16; pc=20, npc=24; fetch_count=5.
//  3 Delayed branch: branch_taken=1 with target=0x40 while pc=8 -> next IF/ID holds pc 8 (slot),
//    then pc 0x40; target 0x43 must behave as 0x40.
//  4 Stall: stall=1 for 3 edges at pc=12 -> all outputs frozen, branch_taken pulse ignored;
//    resumes at 12 after stall drops.
//  5 Flush: flush=1 for 1 edge -> if_id_instr=0, valid=0, fetch_count unchanged, pc still advances;
//    with stall=1 also asserted, pc holds.
//  6 Wrap/async: pc reaches 0x1FC -> the next imem_addr is 0; assert reset mid-cycle ->
//    outputs return to reset values before the next edge.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with PC/nPC delayed-branch sequencing and the IF/ID pipeline register.
// Stall freezes the whole stage; flush turns the IF/ID slot into a bubble.
module if_fetch_stage #(
  parameter int unsigned ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       pc,
  output logic [31:0]       npc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  localparam logic [31:0]      PC_STEP    = 32'd4;
  localparam logic [31:0]      RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_r, npc_r, instr_r, ifpc_r;
  logic             valid_r;
  logic [CNT_W-1:0] cnt_r;

  logic             le_s;
  logic [31:0]      target_s;
  logic [31:0]      pc_nxt_s, npc_nxt_s, instr_nxt_s, ifpc_nxt_s;
  logic             valid_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // PC/nPC sequencing: a taken branch only redirects nPC, giving one delay slot
  always_comb begin
    le_s      = ~stall;
    target_s  = word_align(branch_target);
    pc_nxt_s  = pc_r;
    npc_nxt_s = npc_r;
    if (le_s) begin
      pc_nxt_s  = npc_r;
      npc_nxt_s = branch_taken ? target_s : (npc_r + PC_STEP);
    end else begin
      pc_nxt_s  = pc_r;
      npc_nxt_s = npc_r;
    end
  end

  // IF/ID next state: flush beats stall so a bubble can be injected into a held stage
  always_comb begin
    instr_nxt_s = instr_r;
    ifpc_nxt_s  = ifpc_r;
    valid_nxt_s = valid_r;
    cnt_nxt_s   = cnt_r;
    if (flush) begin
      instr_nxt_s = NOP_WORD;
      valid_nxt_s = 1'b0;
      ifpc_nxt_s  = le_s ? pc_r : ifpc_r;
    end else if (le_s) begin
      instr_nxt_s = imem_data;
      ifpc_nxt_s  = pc_r;
      valid_nxt_s = 1'b1;
      cnt_nxt_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    end else begin
      instr_nxt_s = instr_r;
      ifpc_nxt_s  = ifpc_r;
      valid_nxt_s = valid_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Stage state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r    <= RESET_PC_A;
      npc_r   <= RESET_PC_A + PC_STEP;
      instr_r <= NOP_WORD;
      ifpc_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      pc_r    <= pc_nxt_s;
      npc_r   <= npc_nxt_s;
      instr_r <= instr_nxt_s;
      ifpc_r  <= ifpc_nxt_s;
      valid_r <= valid_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign imem_addr   = pc_r[ADDR_W-1:0];
  assign pc          = pc_r;
  assign npc         = npc_r;
  assign if_id_instr = instr_r;
  assign if_id_pc    = ifpc_r;
  assign if_id_valid = valid_r;
  assign fetch_count = cnt_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized stall/flush/branch/reset traffic compared every cycle against a behavioural model.
module tb_if_fetch_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, stall, flush, branch_taken;
  logic [31:0]   branch_target, imem_data, pc, npc, if_id_instr, if_id_pc;
  logic [8:0]    imem_addr;
  logic          if_id_valid;
  logic [CW-1:0] fetch_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] mem [0:511];

  logic [31:0] m_pc, m_npc, m_instr, m_ifpc;
  logic        m_valid;
  int          m_cnt;

  if_fetch_stage #(.ADDR_W(9), .RESET_PC(32'h0), .NOP_WORD(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .npc(npc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = {mem[imem_addr], mem[imem_addr + 9'd1], mem[imem_addr + 9'd2], mem[imem_addr + 9'd3]};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [8:0] b;
    b = a[8:0];
    return {mem[b], mem[b + 9'd1], mem[b + 9'd2], mem[b + 9'd3]};
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_npc = 32'h4; m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0; m_cnt = 0;
  endtask

  // What one rising edge must do, given the inputs present at that edge
  task automatic model_edge();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (!reset) begin
      model_reset();
    end else begin
      if (flush) begin
        m_instr = 32'h0;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = word_at(old_pc);
        m_ifpc  = old_pc;
        m_valid = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      end
      if (!stall) begin
        m_pc  = m_npc;
        m_npc = branch_taken ? (branch_target & 32'hFFFF_FFFC) : (m_npc + 32'd4);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must reset before the next edge
  task automatic hard_reset();
    @(posedge clk);
    model_edge();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk32("async_rst_pc", pc, 32'h0);
    chk32("async_rst_npc", npc, 32'h4);
    chk32("async_rst_valid", {31'd0, if_id_valid}, 32'h0);
    chk32("async_rst_instr", if_id_instr, 32'h0);
    chk32("async_rst_count", {{(32-CW){1'b0}}, fetch_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk32("pc", pc, m_pc);
      chk32("npc", npc, m_npc);
      chk32("imem_addr", {23'd0, imem_addr}, {23'd0, m_pc[8:0]});
      chk32("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk32("if_id_instr", if_id_instr, m_instr);
      chk32("fetch_count", {{(32-CW){1'b0}}, fetch_count}, m_cnt);
      if (m_valid) chk32("if_id_pc", if_id_pc, m_ifpc);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = (i < 256) ? (i[7:0] ^ 8'h5A) : (i[7:0] ^ 8'hC3);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();
    chk_en = 1'b1;

    // Reset held for three clocks, then sequential fetch
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk32("rel_pc", pc, 32'h0);
    chk32("rel_npc", npc, 32'h4);
    chk32("rel_valid", {31'd0, if_id_valid}, 32'h0);
    tick(); #1;
    chk32("first_ifpc", if_id_pc, 32'h0);
    chk32("first_instr", if_id_instr, 32'h5A5B5859);
    repeat (4) tick(); #1;
    chk32("seq_pc", pc, 32'd20);
    chk32("seq_npc", npc, 32'd24);
    chk32("seq_ifpc", if_id_pc, 32'd16);
    chk32("seq_count", {{(32-CW){1'b0}}, fetch_count}, 32'd5);

    // Delayed branch with an unaligned target
    hard_reset();
    repeat (2) tick(); #1;
    chk32("br_pre_pc", pc, 32'd8);
    branch_taken = 1'b1; branch_target = 32'h43;
    tick(); #1;
    branch_taken = 1'b0; branch_target = 32'h0;
    chk32("br_slot_ifpc", if_id_pc, 32'd8);
    chk32("br_slot_instr", if_id_instr, 32'h52535051);
    chk32("br_npc", npc, 32'h40);
    chk32("br_pc", pc, 32'd12);
    tick(); #1;
    chk32("br_tgt_pc", pc, 32'h40);
    tick(); #1;
    chk32("br_tgt_ifpc", if_id_pc, 32'h40);
    chk32("br_tgt_instr", if_id_instr, 32'h1A1B1819);

    // Stall with an ignored branch pulse, then flush with and without stall
    hard_reset();
    repeat (3) tick(); #1;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    repeat (3) tick(); #1;
    chk32("stall_pc", pc, 32'd12);
    chk32("stall_npc", npc, 32'd16);
    chk32("stall_ifpc", if_id_pc, 32'd8);
    chk32("stall_count", {{(32-CW){1'b0}}, fetch_count}, 32'd3);
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    tick(); #1;
    chk32("resume_ifpc", if_id_pc, 32'd12);
    chk32("resume_npc", npc, 32'd20);
    flush = 1'b1;
    tick(); #1;
    chk32("flush_valid", {31'd0, if_id_valid}, 32'h0);
    chk32("flush_instr", if_id_instr, 32'h0);
    chk32("flush_count", {{(32-CW){1'b0}}, fetch_count}, 32'd4);
    chk32("flush_pc", pc, 32'd20);
    stall = 1'b1;
    tick(); #1;
    chk32("flush_stall_pc", pc, 32'd20);
    chk32("flush_stall_valid", {31'd0, if_id_valid}, 32'h0);
    flush = 1'b0; stall = 1'b0;

    // Fetch address wraps at the top of the 512-byte memory
    hard_reset();
    branch_taken = 1'b1; branch_target = 32'h1FC;
    tick(); #1;
    branch_taken = 1'b0; branch_target = 32'h0;
    tick(); #1;
    chk32("wrap_addr_top", {23'd0, imem_addr}, 32'h1FC);
    tick(); #1;
    chk32("wrap_pc", pc, 32'h200);
    chk32("wrap_addr", {23'd0, imem_addr}, 32'h0);
    chk32("wrap_instr", if_id_instr, 32'h3F3E3D3C);
    hard_reset();

    // Randomized traffic against the model
    repeat (3000) begin
      stall         = ($urandom_range(0, 99) < 20);
      flush         = ($urandom_range(0, 99) < 10);
      branch_taken  = ($urandom_range(0, 99) < 15);
      branch_target = $urandom;
      if ($urandom_range(0, 599) == 0) hard_reset();
      else tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
